// File: rtl/ifetch_resp_unit_pkg.sv
// Shared types and defaults for the instruction-fetch responder.
// Entry layouts: {addr, uncached} request, {addr, data} response.
package ifetch_resp_unit_pkg;

    localparam logic [31:0] IFETCH_RESET_ADDR = 32'h1c00_0000;
    localparam int          IFETCH_DEPTH      = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        uncached;
    } req_ent_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } rsp_ent_t;

    localparam int REQ_W = $bits(req_ent_t);
    localparam int RSP_W = $bits(rsp_ent_t);

endpackage

// File: rtl/ifetch_resp_unit_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers, clear, and exposed slot indices.
// Indices let a parent keep per-slot side bits aligned with the storage.
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic [AW-1:0]    wr_idx,
    output logic [AW-1:0]    rd_idx
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_idx == rd_idx);
    assign count  = wr_ptr - rd_ptr;
    assign rdata  = mem[rd_idx];

    assign do_pop  = pop & ~empty & ~clear;
    assign do_push = push & (~full | do_pop) & ~clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= wdata;
    end

endmodule

// File: rtl/ifetch_resp_unit.sv
// IF0 request responder: issues fetches in order and returns {addr, inst}.
// Optional perf counters are built when IFETCH_PERF_EN is defined.
module ifetch_resp_unit
    import ifetch_resp_unit_pkg::*;
#(
    parameter int          DEPTH      = IFETCH_DEPTH,
    parameter logic [31:0] RESET_ADDR = IFETCH_RESET_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] iaddr,
    input  logic        uncached,
    output logic        addr_ok,
    input  logic        flush,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic [31:0] rsp_addr,
    input  logic        resp_ready,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_uncached,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] perf_req_cnt,
    output logic [31:0] perf_drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    req_ent_t    req_q;
    logic        req_vld;
    logic [AW+1:0] occ;

    logic        accept;
    logic        grant;

    logic        if_push;
    logic        if_pop;
    logic [31:0] if_head;
    logic        if_full;
    logic        if_empty;
    logic [AW:0] if_cnt;
    logic [AW-1:0] if_wr_idx;
    logic [AW-1:0] if_rd_idx;
    logic [DEPTH-1:0] drop_q;
    logic        head_drop;
    logic        ret_disc;

    rsp_ent_t    rsp_wdata;
    rsp_ent_t    rsp_head;
    logic        rsp_push;
    logic        rsp_pop;
    logic        rsp_full;
    logic        rsp_empty;
    logic [AW:0] rsp_cnt;
    logic [AW-1:0] rsp_wr_idx;
    logic [AW-1:0] rsp_rd_idx;

    assign occ = (AW+2)'(req_vld) + (AW+2)'(if_cnt)
               + (AW+2)'(rsp_cnt);

    assign addr_ok = ~rst & ~flush & ~req_vld &
                     (occ < (AW+2)'(DEPTH));
    assign accept  = valid & addr_ok;
    assign grant   = req_vld & mem_gnt;

    assign mem_req      = req_vld;
    assign mem_addr     = req_q.addr;
    assign mem_uncached = req_q.uncached;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_vld <= 1'b0;
            req_q   <= '{addr: RESET_ADDR, uncached: 1'b0};
        end else begin
            if (flush | grant) req_vld <= 1'b0;
            if (accept) begin
                req_vld <= 1'b1;
                req_q   <= '{addr: iaddr, uncached: uncached};
            end
        end
    end

    assign if_push   = grant;
    assign if_pop    = mem_rvalid & ~if_empty;
    assign head_drop = drop_q[if_rd_idx];
    assign ret_disc  = if_pop & (head_drop | flush);

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_inflight (
        .clk    (clk),
        .rst    (rst),
        .push   (if_push),
        .pop    (if_pop),
        .clear  (1'b0),
        .wdata  (req_q.addr),
        .rdata  (if_head),
        .full   (if_full),
        .empty  (if_empty),
        .count  (if_cnt),
        .wr_idx (if_wr_idx),
        .rd_idx (if_rd_idx)
    );

    // Flush marks every slot; a grant in the flush cycle lands pre-marked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
        end else if (flush) begin
            drop_q <= '1;
        end else if (if_push) begin
            drop_q[if_wr_idx] <= 1'b0;
        end
    end

    assign rsp_wdata = '{addr: if_head, data: mem_rdata};
    assign rsp_push  = if_pop & ~head_drop & ~flush;
    assign rsp_pop   = data_ok & resp_ready;

    sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (DEPTH)
    ) u_resp (
        .clk    (clk),
        .rst    (rst),
        .push   (rsp_push),
        .pop    (rsp_pop),
        .clear  (flush),
        .wdata  (rsp_wdata),
        .rdata  (rsp_head),
        .full   (rsp_full),
        .empty  (rsp_empty),
        .count  (rsp_cnt),
        .wr_idx (rsp_wr_idx),
        .rd_idx (rsp_rd_idx)
    );

    assign data_ok  = ~rsp_empty;
    assign rsp_addr = rsp_empty ? RESET_ADDR : rsp_head.addr;
    assign rdata    = rsp_empty ? 32'h0 : rsp_head.data;

`ifdef IFETCH_PERF_EN
    logic [31:0] req_cnt_q;
    logic [31:0] drop_cnt_q;
    logic [AW:0] rsp_flushed;

    // Entries handed to IF1 in the flush cycle are delivered, not dropped.
    assign rsp_flushed = flush ? (rsp_cnt - (AW+1)'(rsp_pop)) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            req_cnt_q  <= req_cnt_q + 32'(accept);
            drop_cnt_q <= drop_cnt_q + 32'(rsp_flushed)
                        + 32'(ret_disc);
        end
    end

    assign perf_req_cnt  = req_cnt_q;
    assign perf_drop_cnt = drop_cnt_q;
`else
    assign perf_req_cnt  = 32'h0;
    assign perf_drop_cnt = 32'h0;
`endif

`ifndef SYNTHESIS
    a_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
        !(mem_rvalid && if_empty))
        else $error("ifetch_resp_unit: mem_rvalid with nothing in flight");

    a_if_space: assert property (@(posedge clk) disable iff (rst)
        !(if_push && if_full && !if_pop));

    a_rsp_space: assert property (@(posedge clk) disable iff (rst)
        !(rsp_push && rsp_full && !rsp_pop));

    a_rsp_ptrs: assert property (@(posedge clk) disable iff (rst)
        rsp_empty |-> (rsp_wr_idx == rsp_rd_idx));

    a_disc_sane: assert property (@(posedge clk) disable iff (rst)
        ret_disc |-> if_pop);
`endif

endmodule

// File: tb/tb_ifetch_resp_unit.sv
// Randomized bench for ifetch_resp_unit against a queue-level reference.
// Perf counter expectations follow IFETCH_PERF_EN.
module tb_ifetch_resp_unit;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_A  = 32'h1c00_0000;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [31:0] iaddr;
    logic        uncached;
    logic        addr_ok;
    logic        flush;
    logic        data_ok;
    logic [31:0] rdata;
    logic [31:0] rsp_addr;
    logic        resp_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_uncached;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] perf_req_cnt;
    logic [31:0] perf_drop_cnt;

    ifetch_resp_unit dut (
        .clk           (clk),
        .rst           (rst),
        .valid         (valid),
        .iaddr         (iaddr),
        .uncached      (uncached),
        .addr_ok       (addr_ok),
        .flush         (flush),
        .data_ok       (data_ok),
        .rdata         (rdata),
        .rsp_addr      (rsp_addr),
        .resp_ready    (resp_ready),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_uncached  (mem_uncached),
        .mem_gnt       (mem_gnt),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .perf_req_cnt  (perf_req_cnt),
        .perf_drop_cnt (perf_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          drop;
    } fl_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } rs_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } mem_t;

    fl_t  m_if[$];
    rs_t  m_rs[$];
    mem_t memq[$];

    bit          m_req_v;
    logic [31:0] m_req_a;
    bit          m_req_u;
    int unsigned m_req_cnt;
    int unsigned m_drop_cnt;

    int errs;
    int checks;
    int cyc;
    int lat_lo;
    int lat_hi;
    int acc_seen;
    bit last_aok;
    logic [31:0] drop_base;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_if.delete();
        m_rs.delete();
        memq.delete();
        m_req_v    = 0;
        m_req_a    = RST_A;
        m_req_u    = 0;
        m_req_cnt  = 0;
        m_drop_cnt = 0;
    endtask

    task automatic idle_inputs();
        valid      = 0;
        iaddr      = 32'h0;
        uncached   = 0;
        flush      = 0;
        resp_ready = 0;
        mem_gnt    = 0;
        mem_rvalid = 0;
        mem_rdata  = 32'h0;
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_addr_ok"},  addr_ok, 0);
        chk({pfx, "_data_ok"},  data_ok, 0);
        chk({pfx, "_mem_req"},  mem_req, 0);
        chk({pfx, "_mem_addr"}, mem_addr, RST_A);
        chk({pfx, "_mem_unc"},  mem_uncached, 0);
        chk({pfx, "_rsp_addr"}, rsp_addr, RST_A);
        chk({pfx, "_rdata"},    rdata, 0);
        chk({pfx, "_perf_req"}, perf_req_cnt, 0);
        chk({pfx, "_perf_drop"}, perf_drop_cnt, 0);
    endtask

    task automatic step(input bit v, input logic [31:0] a, input bit u,
                        input bit fl, input bit rr, input bit g,
                        input bit ret_en);
        bit  e_aok;
        bit  acc;
        bit  grant;
        bit  pop;
        bit  ret;
        fl_t h;
        @(negedge clk);
        valid      = v;
        iaddr      = a;
        uncached   = u;
        flush      = fl;
        resp_ready = rr;
        mem_gnt    = g;
        ret        = ret_en && memq.size() > 0 && memq[0].due <= cyc;
        mem_rvalid = ret;
        mem_rdata  = ret ? memq[0].data : $urandom;
        #1;
        e_aok = !fl && !m_req_v &&
                (int'(m_req_v) + m_if.size() + m_rs.size() < DEPTH);
        last_aok = addr_ok;
        chk("addr_ok", addr_ok, e_aok);
        chk("mem_req", mem_req, m_req_v);
        if (m_req_v) begin
            chk("mem_addr", mem_addr, m_req_a);
            chk("mem_uncached", mem_uncached, m_req_u);
        end
        chk("data_ok", data_ok, m_rs.size() > 0);
        if (m_rs.size() > 0) begin
            chk("rsp_addr", rsp_addr, m_rs[0].addr);
            chk("rdata", rdata, m_rs[0].data);
        end
`ifdef IFETCH_PERF_EN
        chk("perf_req_cnt", perf_req_cnt, m_req_cnt);
        chk("perf_drop_cnt", perf_drop_cnt, m_drop_cnt);
`else
        chk("perf_req_cnt", perf_req_cnt, 0);
        chk("perf_drop_cnt", perf_drop_cnt, 0);
`endif
        acc   = v && e_aok;
        grant = m_req_v && g;
        pop   = m_rs.size() > 0 && rr;
        if (acc) acc_seen++;
        @(posedge clk);
        h = '{addr: 32'h0, drop: 1'b1};
        if (ret) begin
            if (m_if.size() > 0) h = m_if.pop_front();
            void'(memq.pop_front());
        end
        if (grant) begin
            m_if.push_back('{addr: m_req_a, drop: fl});
            memq.push_back('{data: $urandom,
                             due: cyc + $urandom_range(lat_hi, lat_lo)});
        end
        if (fl) foreach (m_if[i]) m_if[i].drop = 1;
        if (pop) void'(m_rs.pop_front());
        if (fl) begin
            m_drop_cnt += m_rs.size();
            m_rs.delete();
        end
        if (ret) begin
            if (h.drop || fl) m_drop_cnt++;
            else m_rs.push_back('{addr: h.addr, data: mem_rdata});
        end
        if (grant || fl) m_req_v = 0;
        if (acc) begin
            m_req_v = 1;
            m_req_a = a;
            m_req_u = u;
            m_req_cnt++;
        end
        cyc++;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(0, 32'h0, 0, 0, 1, 1, 1);
    endtask

    task automatic async_reset();
        @(negedge clk);
        idle_inputs();
        #2;
        rst = 1;
        #1;
        chk_reset_outputs("arst");
        model_clear();
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        errs     = 0;
        checks   = 0;
        cyc      = 0;
        acc_seen = 0;
        lat_lo   = 1;
        lat_hi   = 1;
        model_clear();
        idle_inputs();
        rst   = 1;
        valid = 1;
        #12;
        chk_reset_outputs("rst");
        @(negedge clk);
        idle_inputs();
        rst = 0;

        // single fetch, return 3 cycles after issue
        lat_lo = 3; lat_hi = 3;
        step(1, RST_A, 0, 0, 1, 1, 1);
        drain(8);

        // credit limit
        lat_lo = 1; lat_hi = 1;
        acc_seen = 0;
        for (int i = 0; i < 10; i++)
            step(1, RST_A + 32'(i * 4), i[0], 0, 0, 1, 0);
        chk("credit_accepts", acc_seen, DEPTH);
        for (int i = 0; i < 5; i++) step(0, 32'h0, 0, 0, 0, 1, 1);
        chk("credit_full", last_aok, 0);
        step(0, 32'h0, 0, 0, 1, 1, 1);
        step(1, 32'h1c00_0040, 0, 0, 0, 1, 1);
        chk("credit_reopen", last_aok, 1);
        drain(10);

        // in-order burst
        lat_lo = 2; lat_hi = 2;
        for (int i = 0; i < 3; i++) begin
            step(1, RST_A + 32'(i * 4), 0, 0, 1, 1, 1);
            step(0, 32'h0, 0, 0, 1, 1, 1);
        end
        drain(8);

        // flush with 2 in flight and 1 buffered
        lat_lo = 3; lat_hi = 3;
        drop_base = perf_drop_cnt;
        step(1, 32'h1c00_0010, 0, 0, 0, 1, 1);
        step(0, 32'h0, 0, 0, 0, 1, 1);
        step(1, 32'h1c00_0014, 0, 0, 0, 1, 1);
        step(0, 32'h0, 0, 0, 0, 1, 1);
        step(1, 32'h1c00_0018, 0, 0, 0, 1, 1);
        step(1, 32'h1c00_0020, 0, 1, 0, 1, 1);
        chk("flush_aok", last_aok, 0);
        step(0, 32'h0, 0, 0, 0, 1, 1);
        chk("flush_data_ok", data_ok, 0);
        for (int i = 0; i < 4; i++) step(0, 32'h0, 0, 0, 1, 1, 1);
`ifdef IFETCH_PERF_EN
        chk("flush_drops", perf_drop_cnt - drop_base, 3);
`endif
        step(1, 32'h1c00_0100, 0, 0, 1, 1, 1);
        drain(8);

        // flush coinciding with grant and return
        lat_lo = 2; lat_hi = 2;
        step(1, 32'h1c00_0200, 1, 0, 1, 1, 1);
        step(0, 32'h0, 0, 0, 1, 1, 1);
        step(1, 32'h1c00_0204, 0, 0, 1, 1, 1);
        step(1, 32'h1c00_0208, 0, 1, 1, 1, 1);
        chk("flush_gnt_aok", last_aok, 0);
        drain(8);

        // async reset mid-burst
        lat_lo = 1; lat_hi = 1;
        for (int i = 0; i < 7; i++)
            step(1, 32'h1c00_0300 + 32'(i * 4), 0, 0, 0, 1, 1);
        chk("pre_rst_data_ok", data_ok, 1);
        async_reset();
        drain(4);

        // randomized traffic
        lat_lo = 1; lat_hi = 5;
        for (int i = 0; i < 1500; i++) begin
            if (i == 750) async_reset();
            step($urandom_range(99) < 70,
                 {4'h1, 26'($urandom), 2'b00},
                 1'($urandom),
                 $urandom_range(99) < 5,
                 $urandom_range(99) < 60,
                 $urandom_range(99) < 60,
                 $urandom_range(99) < 70);
        end
        drain(20);
        chk("final_idle", data_ok, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
